sram_controller: RTL



---
 rtl/arm_mem_pkg.sv | 25 ++
 rtl/sram_phase_timer.sv | 32 +++
 rtl/sram_controller.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/arm_mem_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM state encoding,
// default address-map constants and the CPU-address to SRAM-word mapping.
package arm_mem_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'd1024;
    localparam int          DEFAULT_SRAM_ADDR_W = 18;

    // Phase counter width; large enough for the longest legal phase (15 clocks).
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Full-width word index of a CPU byte address; callers keep the low bits
    // they need, which gives the modulo-SRAM-size wrap for free.
    function automatic logic [31:0] sram_word_index(input logic [31:0] address,
                                                    input logic [31:0] base_addr);
        return (address - base_addr) >> 2;
    endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Cycle counter for one 16-bit SRAM phase. Flags the final clock of the phase
// and restarts from zero whenever a new phase begins or the FSM is not in a phase.
module sram_phase_timer
    import arm_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    output logic last_cycle
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Count up while a phase runs; wrap to zero at phase end, on start or when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (start || !run || last_cycle) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign last_cycle = run && (cnt == LAST_CNT);

endmodule

// File: rtl/sram_controller.sv
// Word-to-halfword SRAM responder for the pipeline MEM stage. Each 32-bit
// request becomes two WAIT_CYCLES-long accesses (low half, then high half) on
// an asynchronous 16-bit SRAM; ready stays low while an access is in flight.
// Optional build macro SRAM_ADDR_CHECK_EN: reject misaligned/out-of-range
// requests in IDLE and flag them on err in the completing DONE cycle.
module sram_controller
    import arm_mem_pkg::*;
#(
    parameter int          WAIT_CYCLES = 5,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          SRAM_ADDR_W = DEFAULT_SRAM_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n,
    output logic                   err
);

    localparam int WORD_W = SRAM_ADDR_W - 1;

    state_t state;
    state_t next_state;

    logic              req;
    logic              addr_bad;
    logic              accept;
    logic              last_cycle;
    logic              timer_start;
    logic              timer_run;
    logic [WORD_W-1:0] req_word;

    logic              op_write;
    logic [WORD_W-1:0] word_q;
    logic [31:0]       wdata_q;
    logic [15:0]       lo_q;

    assign req      = wr_en | rd_en;
    assign req_word = WORD_W'(sram_word_index(address, BASE_ADDR));

`ifdef SRAM_ADDR_CHECK_EN
    assign addr_bad = (address[1:0] != 2'b00)
                   || (address < BASE_ADDR)
                   || ((sram_word_index(address, BASE_ADDR) >> WORD_W) != 32'd0);
`else
    assign addr_bad = 1'b0;
`endif

    assign accept      = (state == IDLE) && req && !addr_bad;
    assign timer_run   = (state == LO) || (state == HI);
    assign timer_start = accept || ((state == LO) && last_cycle);

    sram_phase_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .start      (timer_start),
        .run        (timer_run),
        .last_cycle (last_cycle)
    );

    // State register; reset aborts any access in flight straight to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: IDLE -> LO -> HI -> DONE -> IDLE, or IDLE -> DONE on a rejected request.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req) begin
                    next_state = addr_bad ? DONE : LO;
                end
            end
            LO: begin
                if (last_cycle) begin
                    next_state = HI;
                end
            end
            HI: begin
                if (last_cycle) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Capture the request when it is accepted; write wins when both strobes are high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_write <= 1'b0;
            word_q   <= '0;
            wdata_q  <= '0;
        end else if (accept) begin
            op_write <= wr_en;
            word_q   <= req_word;
            wdata_q  <= write_data;
        end
    end

    // Sample SRAM read data on each phase's last clock; the low half waits in a
    // shadow register so read_data only changes when the whole read completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_q      <= '0;
            read_data <= '0;
        end else if (!op_write && last_cycle) begin
            if (state == LO) begin
                lo_q <= sram_dq_in;
            end else if (state == HI) begin
                read_data <= {sram_dq_in, lo_q};
            end
        end
    end

`ifdef SRAM_ADDR_CHECK_EN
    logic err_q;

    // Remember whether the request taken in IDLE was rejected; shown only in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((state == IDLE) && req) begin
            err_q <= addr_bad;
        end
    end

    assign err = err_q && (state == DONE);
`else
    assign err = 1'b0;
`endif

    // Bus and handshake outputs: strobe low for all but the last clock of a write phase.
    always_comb begin
        ready       = 1'b0;
        sram_addr   = {word_q, 1'b0};
        sram_dq_out = 16'h0000;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state)
            IDLE: begin
                ready = !wr_en && !rd_en;
            end
            LO: begin
                if (op_write) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[15:0];
                    sram_we_n   = last_cycle;
                end
            end
            HI: begin
                sram_addr = {word_q, 1'b1};
                if (op_write) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[31:16];
                    sram_we_n   = last_cycle;
                end
            end
            DONE: begin
                ready = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

endmodule
